uart_cfg: RTL

UART_CFG -- requirements
Module: uart_cfg

---
 rtl/uart_cfg.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cfg.sv
// uart_cfg: parameterised UART transmitter and receiver sharing one clock.
// Timing is built from a 16x oversample tick (DIV clk cycles per tick).
// TX and RX keep separate prescaler and tick counters.
//
// TX handshake (valid/ready): a word transfers on a rising clk edge where
// txValid and txReady are both high. txReady is high only when the
// transmitter is idle, enabled and out of reset. txData is latched at the
// transfer edge, so the producer may change it on the next cycle.
module uart_cfg #(
    parameter int CLOCK_RATE = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 rx,
    input  logic                 rxEn,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 rxValid,
    output logic                 rxErrFrame,
    output logic                 rxErrParity,
    output logic                 rxBusy,
    output logic                 tx,
    input  logic                 txEn,
    input  logic [DATA_BITS-1:0] txData,
    input  logic                 txValid,
    output logic                 txReady,
    output logic [2:0]           tx_fsm,
    output logic [2:0]           rx_fsm
);

    localparam int DIV_RAW = (CLOCK_RATE + 8 * BAUD_RATE) / (16 * BAUD_RATE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0] PRESC_MAX  = PW'(DIV - 1);
    localparam logic [3:0]    LAST_BIT   = 4'(DATA_BITS - 1);
    localparam logic          LAST_STOP  = (STOP_BITS == 2);
    localparam logic          HAS_PARITY = (PARITY != 0);
    localparam logic          ODD        = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t                 tx_state, tx_next;
    logic [PW-1:0]          tx_presc;
    logic [3:0]             tx_tick_cnt;
    logic [DATA_BITS-1:0]   tx_shreg;
    logic [3:0]             tx_bit_idx;
    logic                   tx_stop_idx;
    logic                   tx_par;
    logic                   run;
    logic                   tx_tick, tx_bit_end, tx_take;

    assign tx_tick    = (tx_presc == PRESC_MAX);
    assign tx_bit_end = tx_tick && (tx_tick_cnt == 4'd15);
    assign txReady    = (tx_state == S_IDLE) && txEn && run;
    assign tx_take    = txReady && txValid;
    assign tx_fsm     = tx_state;

    // Holds txReady low until the first clock edge after reset release.
    always_ff @(posedge clk) begin
        if (!rstN) run <= 1'b0;
        else       run <= 1'b1;
    end

    // TX state register.
    always_ff @(posedge clk) begin
        if (!rstN) tx_state <= S_IDLE;
        else       tx_state <= tx_next;
    end

    // TX next state: each serial bit lasts 16 ticks.
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            S_IDLE:   if (tx_take) tx_next = S_START;
            S_START:  if (tx_bit_end) tx_next = S_DATA;
            S_DATA:   if (tx_bit_end && tx_bit_idx == LAST_BIT)
                          tx_next = HAS_PARITY ? S_PARITY : S_STOP;
            S_PARITY: if (tx_bit_end) tx_next = S_STOP;
            S_STOP:   if (tx_bit_end && tx_stop_idx == LAST_STOP)
                          tx_next = S_IDLE;
            default:  tx_next = S_IDLE;
        endcase
    end

    // TX datapath: latch the word, run the bit timer, shift data out.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            tx_presc    <= '0;
            tx_tick_cnt <= '0;
            tx_shreg    <= '0;
            tx_bit_idx  <= '0;
            tx_stop_idx <= 1'b0;
            tx_par      <= 1'b0;
        end else if (tx_take) begin
            tx_presc    <= '0;
            tx_tick_cnt <= '0;
            tx_shreg    <= txData;
            tx_bit_idx  <= '0;
            tx_stop_idx <= 1'b0;
            tx_par      <= (^txData) ^ ODD;
        end else if (tx_state != S_IDLE) begin
            tx_presc <= tx_tick ? '0 : tx_presc + 1'b1;
            if (tx_tick) tx_tick_cnt <= tx_tick_cnt + 1'b1;
            if (tx_bit_end && tx_state == S_DATA) begin
                tx_shreg   <= tx_shreg >> 1;
                tx_bit_idx <= tx_bit_idx + 1'b1;
            end
            if (tx_bit_end && tx_state == S_STOP) tx_stop_idx <= tx_stop_idx + 1'b1;
        end
    end

    // Serial line level decoded from the TX state (idle and stop are high).
    always_comb begin
        tx = 1'b1;
        case (tx_state)
            S_START:  tx = 1'b0;
            S_DATA:   tx = tx_shreg[0];
            S_PARITY: tx = tx_par;
            default:  tx = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    state_t                 rx_state, rx_next;
    logic                   rx_meta, rx_sync, rx_prev;
    logic [PW-1:0]          rx_presc;
    logic [3:0]             rx_tick_cnt;
    logic [DATA_BITS-1:0]   rx_shreg;
    logic [3:0]             rx_bit_idx;
    logic                   rx_stop_idx;
    logic                   rx_ferr, rx_perr;
    logic                   rx_fall, rx_tick, rx_sample;

    assign rx_fall   = rx_prev && !rx_sync;
    assign rx_tick   = (rx_presc == PRESC_MAX);
    // Tick 8 of the start bit is mid-bit; every later sample is 16 ticks on,
    // which lands on the same counter value because the counter wraps at 16.
    assign rx_sample = rx_tick && (rx_tick_cnt == 4'd7);
    assign rx_fsm    = rx_state;
    assign rxBusy    = (rx_state == S_START) || (rx_state == S_DATA) ||
                       (rx_state == S_PARITY) || (rx_state == S_STOP);

    // Two-flop synchronizer plus one delayed copy for falling-edge detect.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // RX state register.
    always_ff @(posedge clk) begin
        if (!rstN) rx_state <= S_IDLE;
        else       rx_state <= rx_next;
    end

    // RX next state: disable aborts; a break parks in WAIT_HIGH.
    always_comb begin
        rx_next = rx_state;
        if (!rxEn) begin
            rx_next = S_IDLE;
        end else begin
            case (rx_state)
                S_IDLE:      if (rx_fall) rx_next = S_START;
                S_START:     if (rx_sample) rx_next = rx_sync ? S_IDLE : S_DATA;
                S_DATA:      if (rx_sample && rx_bit_idx == LAST_BIT)
                                 rx_next = HAS_PARITY ? S_PARITY : S_STOP;
                S_PARITY:    if (rx_sample) rx_next = S_STOP;
                S_STOP:      if (rx_sample && rx_stop_idx == LAST_STOP)
                                 rx_next = rx_sync ? S_IDLE : S_WAIT_HIGH;
                S_WAIT_HIGH: if (rx_sync) rx_next = S_IDLE;
                default:     rx_next = S_IDLE;
            endcase
        end
    end

    // RX datapath: bit timer, shift-in, error accumulation, word delivery.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            rx_presc    <= '0;
            rx_tick_cnt <= '0;
            rx_shreg    <= '0;
            rx_bit_idx  <= '0;
            rx_stop_idx <= 1'b0;
            rx_ferr     <= 1'b0;
            rx_perr     <= 1'b0;
            rxData      <= '0;
            rxValid     <= 1'b0;
            rxErrFrame  <= 1'b0;
            rxErrParity <= 1'b0;
        end else begin
            rxValid <= 1'b0;
            if (rxEn && rx_state == S_IDLE && rx_fall) begin
                rx_presc    <= '0;
                rx_tick_cnt <= '0;
                rx_bit_idx  <= '0;
                rx_stop_idx <= 1'b0;
                rx_ferr     <= 1'b0;
                rx_perr     <= 1'b0;
            end else if (rxEn && rxBusy) begin
                rx_presc <= rx_tick ? '0 : rx_presc + 1'b1;
                if (rx_tick) rx_tick_cnt <= rx_tick_cnt + 1'b1;
                if (rx_sample) begin
                    case (rx_state)
                        S_DATA: begin
                            rx_shreg   <= {rx_sync, rx_shreg[DATA_BITS-1:1]};
                            rx_bit_idx <= rx_bit_idx + 1'b1;
                        end
                        S_PARITY: rx_perr <= rx_sync ^ (^rx_shreg) ^ ODD;
                        S_STOP: begin
                            rx_ferr     <= rx_ferr | !rx_sync;
                            rx_stop_idx <= rx_stop_idx + 1'b1;
                            if (rx_stop_idx == LAST_STOP) begin
                                rxValid     <= 1'b1;
                                rxData      <= rx_shreg;
                                rxErrFrame  <= rx_ferr | !rx_sync;
                                rxErrParity <= rx_perr;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
